inst_rom_ctrl: RTL and testbench

// - Instruction-memory responder for the CPU fetch port (CPU drives rom_ce_o/rom_addr_o, samples rom_data_i).
// - Holds a word-addressed program store and answers fetches combinationally, so the registered PC and the IF/ID latch see data in the same cycle.
// - Includes a byte-stream program loader that assembles big-endian words and holds the CPU in reset while a program is loaded.

---
 rtl/inst_rom_ctrl.sv | 129 ++++++++++++
 tb/tb_inst_rom_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_ctrl.sv
// Instruction store for the CPU fetch port, with a big-endian byte-stream loader
// that holds the CPU in reset while loading. Define INST_ROM_INIT_EN to come out
// of reset already running.
module inst_rom_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              cpu_rst_o,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_done_i,
  output logic              ld_ready_o,
  output logic [ADDR_W:0]   ld_words_o,
  output logic              ld_ovf_o,
  output logic              oor_o
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

`ifdef INST_ROM_INIT_EN
  localparam logic [1:0] S_RST = S_RUN;
`else
  localparam logic [1:0] S_RST = S_IDLE;
`endif

  logic [1:0]        r_state;
  logic [31:0]       r_buf;
  logic [1:0]        r_cnt;
  logic [ADDR_W:0]   r_wptr;
  logic              r_ovf;
  logic [31:0]       r_mem [DEPTH];

  logic              w_full;
  logic              w_accept;
  logic              w_wr_en;
  logic [31:0]       w_wr_data;
  logic [ADDR_W-1:0] w_idx;
  logic              w_hi;
  logic              w_unused;

  // wptr never passes DEPTH, so its top bit alone flags a full store
  assign w_full   = r_wptr[ADDR_W];
  assign w_accept = (r_state == S_LOAD) && ld_valid_i && !ld_start_i;

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = 32'h0;
    if (!rst && w_accept && !w_full && (r_cnt == 2'd3)) begin
      w_wr_en   = 1'b1;
      w_wr_data = {r_buf[23:0], ld_byte_i};
    end else if (!rst && !ld_start_i && (r_state == S_FLUSH) && (r_cnt != 2'd0) && !w_full) begin
      w_wr_en = 1'b1;
      case (r_cnt)
        2'd1:    w_wr_data = {r_buf[7:0], 24'h0};
        2'd2:    w_wr_data = {r_buf[15:0], 16'h0};
        default: w_wr_data = {r_buf[23:0], 8'h0};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr[ADDR_W-1:0]] <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RST;
      r_buf   <= 32'h0;
      r_cnt   <= 2'd0;
      r_wptr  <= '0;
      r_ovf   <= 1'b0;
    end else if (ld_start_i) begin
      // start wins over everything, including a coincident done
      r_state <= S_LOAD;
      r_buf   <= 32'h0;
      r_cnt   <= 2'd0;
      r_wptr  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (ld_valid_i) begin
            if (w_full) begin
              r_ovf <= 1'b1;
            end else begin
              r_buf <= {r_buf[23:0], ld_byte_i};
              if (r_cnt == 2'd3) begin
                r_cnt  <= 2'd0;
                r_wptr <= r_wptr + 1'b1;
              end else begin
                r_cnt <= r_cnt + 2'd1;
              end
            end
          end
          if (ld_done_i) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if ((r_cnt != 2'd0) && !w_full) r_wptr <= r_wptr + 1'b1;
          r_cnt   <= 2'd0;
          r_buf   <= 32'h0;
          r_state <= S_RUN;
        end
        default: ;
      endcase
    end
  end

  assign w_idx    = rom_addr_i[ADDR_W+1:2];
  assign w_hi     = |rom_addr_i[31:ADDR_W+2];
  assign w_unused = ^rom_addr_i[1:0];

  assign oor_o      = rom_ce_i && w_hi;
  assign rom_data_o = ((r_state == S_RUN) && rom_ce_i && !w_hi) ? r_mem[w_idx] : 32'h0;
  assign cpu_rst_o  = (r_state != S_RUN);
  assign ld_ready_o = (r_state == S_LOAD);
  assign ld_words_o = r_wptr;
  assign ld_ovf_o   = r_ovf;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Drives a 1024-word and a 4-word store with the same stimulus and checks both
// against a byte-list model of the loader and fetch rules.
module tb_inst_rom_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rom_ce, ld_start, ld_valid, ld_done;
  logic [31:0] rom_addr;
  logic [7:0]  ld_byte;

  logic [31:0] data_b, data_s;
  logic        cpurst_b, cpurst_s, ready_b, ready_s, ovf_b, ovf_s, oor_b, oor_s;
  logic [10:0] words_b;
  logic [2:0]  words_s;

  inst_rom_ctrl #(.ADDR_W(10)) dut_b (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr),
    .rom_data_o(data_b), .cpu_rst_o(cpurst_b), .ld_start_i(ld_start),
    .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_done_i(ld_done),
    .ld_ready_o(ready_b), .ld_words_o(words_b), .ld_ovf_o(ovf_b), .oor_o(oor_b));

  inst_rom_ctrl #(.ADDR_W(2)) dut_s (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr),
    .rom_data_o(data_s), .cpu_rst_o(cpurst_s), .ld_start_i(ld_start),
    .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_done_i(ld_done),
    .ld_ready_o(ready_s), .ld_words_o(words_s), .ld_ovf_o(ovf_s), .oor_o(oor_s));

  int n_checks = 0;
  int n_err    = 0;

  // Model: phase 0 idle, 1 loading, 2 flushing, 3 running; pending bytes in a list
  int          aw [2] = '{10, 2};
  int          ph [2];
  logic [7:0]  pb [2][4];
  int          nb [2];
  int          mw [2];
  bit          mo [2];
  logic [31:0] mm [2][1024];
  bit          mv [2][1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k] = 0; nb[k] = 0; mw[k] = 0; mo[k] = 0;
      end else if (ld_start) begin
        ph[k] = 1; nb[k] = 0; mw[k] = 0; mo[k] = 0;
      end else if (ph[k] == 1) begin
        if (ld_valid) begin
          if (mw[k] == (1 << aw[k])) mo[k] = 1;
          else begin
            pb[k][nb[k]] = ld_byte;
            nb[k]++;
            if (nb[k] == 4) begin
              mm[k][mw[k]] = {pb[k][0], pb[k][1], pb[k][2], pb[k][3]};
              mv[k][mw[k]] = 1;
              mw[k]++;
              nb[k] = 0;
            end
          end
        end
        if (ld_done) ph[k] = 2;
      end else if (ph[k] == 2) begin
        if (nb[k] > 0) begin
          logic [31:0] w;
          w = 32'h0;
          for (int i = 0; i < nb[k]; i++) w[31-8*i -: 8] = pb[k][i];
          mm[k][mw[k]] = w;
          mv[k][mw[k]] = 1;
          mw[k]++;
          nb[k] = 0;
        end
        ph[k] = 3;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] d, dexp;
    logic        o;
    int          idx;
    bit          hi;
    for (int k = 0; k < 2; k++) begin
      string s;
      s = (k == 0) ? "b" : "s";
      chk({"cpu_rst_", s}, (k == 0) ? 32'(cpurst_b) : 32'(cpurst_s), 32'(ph[k] != 3));
      chk({"ready_", s},   (k == 0) ? 32'(ready_b)  : 32'(ready_s),  32'(ph[k] == 1));
      chk({"words_", s},   (k == 0) ? 32'(words_b)  : 32'(words_s),  32'(mw[k]));
      chk({"ovf_", s},     (k == 0) ? 32'(ovf_b)    : 32'(ovf_s),    32'(mo[k]));
      idx = int'(rom_addr >> 2) & ((1 << aw[k]) - 1);
      hi  = (rom_addr >> (aw[k] + 2)) != 0;
      o   = (k == 0) ? oor_b : oor_s;
      d   = (k == 0) ? data_b : data_s;
      chk({"oor_", s}, 32'(o), 32'(rom_ce && hi));
      if (!(ph[k] == 3 && rom_ce && !hi)) chk({"nop_", s}, d, 32'h0);
      else if (mv[k][idx]) begin
        dexp = mm[k][idx];
        chk({"fetch_", s}, d, dexp);
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic fetch(input logic ce, input logic [31:0] a);
    rom_ce = ce; rom_addr = a;
    #1;
    check_all();
  endtask

  task automatic put(input logic [7:0] b);
    ld_valid = 1'b1; ld_byte = b;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1; step(); ld_start = 1'b0;
  endtask

  task automatic finish_load();
    ld_done = 1'b1; step(); ld_done = 1'b0;
    step();
    step();
  endtask

  initial begin
    logic [7:0] p1 [8];
    logic [7:0] p2 [5];
    p1 = '{8'h34, 8'h01, 8'h00, 8'h10, 8'h34, 8'h02, 8'h00, 8'h20};
    p2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rst = 1'b1; rom_ce = 1'b0; rom_addr = 32'h0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_done = 1'b0; ld_byte = 8'h0;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 1024; i++) mv[k][i] = 0;
    step();
    step();
    chk("rst_cpu_rst", 32'(cpurst_b), 32'h1);
    chk("rst_words",   32'(words_b),  32'h0);
    rst = 1'b0;
    step();

    // Two-word program, done on its own cycle
    pulse_start();
    chk("load_ready", 32'(ready_b), 32'h1);
    for (int i = 0; i < 8; i++) put(p1[i]);
    ld_done = 1'b1; step(); ld_done = 1'b0;
    chk("flush_cpu_rst", 32'(cpurst_b), 32'h1);
    chk("flush_ready",   32'(ready_b),  32'h0);
    step();
    chk("run_cpu_rst", 32'(cpurst_b), 32'h0);
    chk("words_2",     32'(words_b),  32'd2);
    fetch(1'b1, 32'h0);
    chk("addr0", data_b, 32'h34010010);
    fetch(1'b1, 32'h4);
    chk("addr4", data_b, 32'h34020020);
    fetch(1'b0, 32'h4);
    chk("ce0", data_b, 32'h0);
    fetch(1'b1, 32'h00001000);
    chk("oor_data", data_b, 32'h0);
    chk("oor_flag", 32'(oor_b), 32'h1);
    fetch(1'b1, 32'h00000006);
    chk("addr6", data_b, 32'h34020020);

    // Partial word with done on the last byte
    pulse_start();
    for (int i = 0; i < 4; i++) put(p2[i]);
    ld_valid = 1'b1; ld_byte = p2[4]; ld_done = 1'b1;
    step();
    ld_valid = 1'b0; ld_done = 1'b0;
    step();
    fetch(1'b1, 32'h4);
    chk("partial", data_b, 32'h55000000);
    chk("partial_words", 32'(words_b), 32'd2);

    // 17 bytes: overflows the 4-word store
    pulse_start();
    for (int i = 0; i < 17; i++) put(8'(i + 1));
    finish_load();
    chk("ovf_small",   32'(ovf_s),   32'h1);
    chk("words_small", 32'(words_s), 32'd4);
    fetch(1'b1, 32'hC);
    chk("small_w3", data_s, 32'h0D0E0F10);

    // Random loads with gaps and occasional restarts
    for (int it = 0; it < 8; it++) begin
      int n;
      pulse_start();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        ld_valid = ($urandom % 4) != 0;
        ld_byte  = 8'($urandom);
        ld_start = ($urandom % 30) == 0;
        ld_done  = (i == n - 1);
        step();
      end
      ld_valid = 1'b0; ld_start = 1'b0; ld_done = 1'b0;
      step();
      step();
      for (int j = 0; j < 10; j++) begin
        if ($urandom % 5 == 0) fetch(1'b1, $urandom);
        else fetch(($urandom % 6) != 0, 32'($urandom_range(0, 31)));
      end
    end

    // Restart from RUN, then reset before done: load abandoned, word 0 kept
    pulse_start();
    chk("restart_cpu_rst", 32'(cpurst_b), 32'h1);
    put(8'hDE); put(8'hAD); put(8'hBE); put(8'hEF);
    rst = 1'b1; step(); rst = 1'b0;
    chk("abandon_cpu_rst", 32'(cpurst_b), 32'h1);
    chk("abandon_words",   32'(words_b),  32'h0);
    chk("abandon_ready",   32'(ready_b),  32'h0);
    pulse_start();
    finish_load();
    fetch(1'b1, 32'h0);
    chk("kept_w0", data_b, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
